// File: rtl/burst_memory.sv
// rtl/burst_memory.sv - byte-addressable big-endian burst memory (optional MEM_BOUNDS_CHECK_EN adds err)
module burst_memory #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            access_size,
    input  logic                  rw,
    input  logic                  enable,
    output logic                  busy,
    output logic                  rd_valid,
`ifdef MEM_BOUNDS_CHECK_EN
    output logic                  err,
`endif
    output logic [DATA_WIDTH-1:0] data_out
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int IW  = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

    state_t                state, state_nx;
    logic [3:0]            beat, last;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [7:0]            mem [DEPTH];

    logic                  accept, active, beat_rd, final_beat, beat_ok;
    logic [3:0]            size_last, beat_now, beat_last;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [IW-1:0]         byte_idx [BPW];
    logic [DATA_WIDTH-1:0] rdata;

    // In IDLE the beat is taken straight from the request inputs so beat 0 runs on the accept edge.
    always_comb begin
        case (access_size)
            2'b00:   size_last = 4'd0;
            2'b01:   size_last = 4'd3;
            2'b10:   size_last = 4'd7;
            default: size_last = 4'd15;
        endcase
        accept     = (state == IDLE) && enable;
        active     = accept || (state != IDLE);
        beat_addr  = (state == IDLE) ? (address - START_ADDR) : cur_addr;
        beat_rd    = (state == IDLE) ? rw : (state == RD_BURST);
        beat_now   = (state == IDLE) ? 4'd0 : beat;
        beat_last  = (state == IDLE) ? size_last : last;
        final_beat = (beat_now == beat_last);
        for (int i = 0; i < BPW; i++) begin
            byte_idx[i] = IW'((beat_addr + ADDR_WIDTH'(i)) % ADDR_WIDTH'(DEPTH));
        end
`ifdef MEM_BOUNDS_CHECK_EN
        // Offset is unsigned, so an address below START_ADDR lands far above DEPTH.
        beat_ok = (({1'b0, beat_addr} + (ADDR_WIDTH+1)'(BPW - 1)) < (ADDR_WIDTH+1)'(DEPTH));
`else
        beat_ok = 1'b1;
`endif
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < BPW; i++) begin
            rdata[DATA_WIDTH-1-8*i -: 8] = mem[byte_idx[i]];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept && !final_beat) state_nx = rw ? RD_BURST : WR_BURST;
            RD_BURST,
            WR_BURST: if (final_beat) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            beat     <= 4'd0;
            last     <= 4'd0;
            cur_addr <= '0;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            data_out <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
            err      <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            busy     <= active && !final_beat;
            rd_valid <= active && beat_rd;
            if (active) begin
                cur_addr <= beat_addr + ADDR_WIDTH'(BPW);
                beat     <= final_beat ? 4'd0 : beat_now + 4'd1;
                if (accept) last <= size_last;
                if (beat_rd) data_out <= beat_ok ? rdata : '0;
`ifdef MEM_BOUNDS_CHECK_EN
                if (!beat_ok) err <= 1'b1;
`endif
            end
        end
    end

    // Gated by reset_n so an asserted reset blocks any write on a coincident edge.
    always_ff @(posedge clock) begin
        if (reset_n && active && !beat_rd && beat_ok) begin
            for (int i = 0; i < BPW; i++) begin
                mem[byte_idx[i]] <= data_in[DATA_WIDTH-1-8*i -: 8];
            end
        end
    end
endmodule

// File: tb/tb_burst_memory.sv
// tb/tb_burst_memory.sv - directed self-checking bench for burst_memory
module tb_burst_memory;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] START = 32'h80020000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  access_size = '0;
    logic        rw = 1'b0;
    logic        enable = 1'b0;
    logic        busy, rd_valid;
    logic [31:0] data_out;
`ifdef MEM_BOUNDS_CHECK_EN
    logic        err;
`endif

    burst_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .START_ADDR(START)) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .data_in(data_in),
        .access_size(access_size), .rw(rw), .enable(enable), .busy(busy),
        .rd_valid(rd_valid),
`ifdef MEM_BOUNDS_CHECK_EN
        .err(err),
`endif
        .data_out(data_out)
    );

    always #5 clock = ~clock;

    int          checks = 0, errors = 0;
    int          busy_cnt = 0, valid_cnt = 0;
    logic [7:0]  mdl [DEPTH];
    logic        exp_busy = 1'b0, exp_valid = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_data = '0;
    bit          check_en = 1'b0;
    logic [31:0] wbuf [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
            chk("data_out", data_out, exp_data);
`ifdef MEM_BOUNDS_CHECK_EN
            chk("err", 32'(err), 32'(exp_err));
`endif
            busy_cnt  += int'(busy);
            valid_cnt += int'(rd_valid);
        end
    end

    function automatic bit outside(input logic [31:0] b);
        logic [32:0] lim = 33'(START) + 33'(DEPTH);
        return (b < START) || (33'(b) >= lim);
    endfunction

    function automatic int mi(input logic [31:0] b);
        logic [31:0] o = b - START;
        return int'(o % 32'(DEPTH));
    endfunction

    // One beat of the reference model: byte-wise big-endian access at byte address a.
    task automatic model_beat(input bit rd, input logic [31:0] a, input logic [31:0] wd);
        bit bad = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
        for (int i = 0; i < 4; i++) bad |= outside(a + 32'(i));
`endif
        exp_valid = rd;
        if (bad) begin
            exp_err = 1'b1;
            if (rd) exp_data = '0;
        end else if (rd) begin
            exp_data = {mdl[mi(a)], mdl[mi(a + 1)], mdl[mi(a + 2)], mdl[mi(a + 3)]};
        end else begin
            for (int i = 0; i < 4; i++) mdl[mi(a + 32'(i))] = wd[31-8*i -: 8];
        end
    endtask

    task automatic burst(input bit rd, input logic [31:0] a, input logic [1:0] sz,
                         input bit toggle, input bit keep_en, input int stop_at);
        int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 4 : (sz == 2'd2) ? 8 : 16;
        enable = 1'b1; rw = rd; address = a; access_size = sz; data_in = wbuf[0];
        for (int k = 0; k < n && k < stop_at; k++) begin
            @(posedge clock); #1;
            model_beat(rd, a + 32'(4 * k), wbuf[k]);
            exp_busy = (k < n - 1);
            if (k + 1 < n) data_in = wbuf[k + 1];
            if (toggle) begin
                address = $urandom; rw = 1'($urandom); access_size = 2'($urandom);
                enable = (k + 2 == n) ? 1'b1 : 1'($urandom);
            end
        end
        enable = keep_en;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            exp_valid = 1'b0; exp_busy = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_data_out", data_out, 32'd0);
        @(posedge clock); #1 reset_n = 1'b1; check_en = 1'b1;
        idle(2);

        wbuf[0] = 32'hDEADBEEF; busy_cnt = 0;
        burst(1'b0, START, 2'b00, 1'b0, 1'b0, 16);
        idle(1);
        chk("byte_order_mem0", 32'(dut.mem[0]), 32'hDE);
        chk("byte_order_mem3", 32'(dut.mem[3]), 32'hEF);
        burst(1'b1, START, 2'b00, 1'b0, 1'b0, 16);
        idle(1);
        chk("single_read", data_out, 32'hDEADBEEF);
        chk("single_busy_cycles", 32'(busy_cnt), 32'd0);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        busy_cnt = 0;
        burst(1'b0, START + 32'h10, 2'b01, 1'b0, 1'b0, 16);
        idle(1);
        chk("wr4_busy_cycles", 32'(busy_cnt), 32'd3);
        valid_cnt = 0;
        burst(1'b1, START + 32'h10, 2'b01, 1'b0, 1'b0, 16);
        idle(1);
        chk("rd4_last_word", data_out, 32'd4);
        chk("rd4_valid_count", 32'(valid_cnt), 32'd4);

        for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
        burst(1'b0, START + 32'h100, 2'b11, 1'b0, 1'b0, 16);
        idle(1);
        valid_cnt = 0; busy_cnt = 0;
        burst(1'b1, START + 32'h100, 2'b11, 1'b1, 1'b0, 16);
        idle(2);
        chk("rd16_valid_count", 32'(valid_cnt), 32'd16);
        chk("rd16_busy_cycles", 32'(busy_cnt), 32'd15);
        chk("rd16_last_word", data_out, wbuf[15]);

        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        valid_cnt = 0;
        burst(1'b0, START + 32'h200, 2'b10, 1'b0, 1'b1, 16);
        burst(1'b1, START + 32'h200, 2'b10, 1'b0, 1'b0, 16);
        idle(1);
        chk("b2b_valid_count", 32'(valid_cnt), 32'd8);
        chk("b2b_last_word", data_out, wbuf[7]);

        burst(1'b1, START + 32'h100, 2'b11, 1'b1, 1'b0, 5);
        #2 reset_n = 1'b0;
        exp_busy = 1'b0; exp_valid = 1'b0; exp_data = '0; exp_err = 1'b0;
        #1;
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("async_reset_data_out", data_out, 32'd0);
        @(posedge clock); #1 reset_n = 1'b1;
        idle(1);
        burst(1'b1, START, 2'b00, 1'b0, 1'b0, 16);
        idle(1);
        chk("post_reset_read", data_out, 32'hDEADBEEF);

        wbuf[0] = 32'hAABBCCDD;
        burst(1'b0, START + 32'(DEPTH) - 32'd2, 2'b00, 1'b0, 1'b0, 16);
        idle(1);
        burst(1'b1, START, 2'b00, 1'b0, 1'b0, 16);
        idle(1);
`ifdef MEM_BOUNDS_CHECK_EN
        chk("bounds_err", 32'(err), 32'd1);
        chk("bounds_no_write", data_out, 32'hDEADBEEF);
        burst(1'b1, START + 32'(DEPTH) - 32'd2, 2'b00, 1'b0, 1'b0, 16);
        idle(1);
        chk("bounds_read_zero", data_out, 32'd0);
`else
        chk("wrap_write", data_out, 32'hCCDDBEEF);
`endif
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
